axis_packet_mux: RTL and testbench
==================================

Name: axis_packet_mux

Overview:
- N-input to 1-output AXI-Stream packet multiplexer; parametrised successor of the two-source byte mux.
- Arbitrates only on packet boundaries (TLAST) and forwards whole packets from the granted source through one registered output stage.
- Full valid/ready backpressure: when the sink deasserts ready, the granted source stalls and the output holds stable.
- Sits between the per-channel source modules and the single downstream sink.

Parameters:
- NUM_SRC, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel, in bits.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_W, $clog2(NUM_SRC), width of the source index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  NUM_SRC  per-source TVALID.
- s_last  in  NUM_SRC  per-source TLAST.
- s_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- s_ready  out  NUM_SRC  per-source TREADY; at most one bit set (one-hot or zero).
- m_valid  out  1  output TVALID (registered).
- m_last  out  1  output TLAST (registered).
- m_data  out  DATA_W  output TDATA (registered).
- m_src  out  SRC_W  index of the source that produced the current m_data beat (registered).
- m_ready  in  1  sink TREADY.
- busy  out  1  high while in XFER state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: m_valid=0, m_last=0, m_data=0, m_src=0, s_ready=0, busy=0, state=IDLE, round-robin pointer=0, grant=0.
- Reset mid-packet: the partial packet is abandoned and the output beat is dropped (m_valid=0 next cycle). No recovery of the remainder.
- Output register: can_load = m_ready | ~m_valid.
  - m_valid/m_last/m_data/m_src change only when can_load=1.
  - While m_valid=1 and m_ready=0, all m_* outputs hold (AXI stability rule).
- FSM states: IDLE, XFER.
- IDLE:
  - s_ready = 0.
  - If any s_valid, the arbiter picks grant g; register g and go to XFER next cycle.
  - If no s_valid, stay in IDLE.
  - When can_load=1, clear m_valid.
- XFER:
  - s_ready = (1<<g) & {NUM_SRC{can_load}}; combinational from m_ready and m_valid.
  - A beat transfers when s_valid[g] & s_ready[g]. It loads m_data=s_data[g], m_last=s_last[g], m_src=g, m_valid=1.
  - If can_load=1 and s_valid[g]=0, load m_valid=0 (bubble); stay in XFER.
  - If the transferred beat has s_last[g]=1, go to IDLE next cycle; the round-robin pointer becomes (g+1) mod NUM_SRC.
- Arbitration:
  - Round-robin: first set s_valid scanning from the pointer upward, with wrap-around.
  - Fixed priority: lowest set index; the pointer is ignored.
  - Valid assertions on non-granted sources are ignored; they wait.
- Latency:
  - Grant is decided in IDLE cycle t; s_ready rises at t+1; that beat appears on m_* at t+2.
  - Exactly one IDLE cycle between consecutive packets (1 bubble per packet).
- Single-beat packet (valid & last in the first XFER cycle): transferred, then IDLE.
- Sink backpressure: m_ready=0 with m_valid=1 drops s_ready to 0 in the same cycle. The granted source holds its beat; the grant does not change.
- Simultaneous last on output (m_ready=1) and new source beat: both occur; no loss, no duplication.
- Source behaviour is assumed AXI-compliant; a valid drop mid-packet only creates bubbles, with no timeout.

Decomposition:
- Shared package axis_mux_pkg holds:
  - state enum {IDLE, XFER};
  - ARB_RR=0 and ARB_FIXED=1 constants;
  - an index-width helper function.
- Sub-module axis_rr_arbiter (NUM_SRC, ARB_MODE): combinational.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any_req.
  - Reused by future demux and crossbar blocks.

Test Plan:
- Round-robin fairness: NUM_SRC=4, all sources valid, each sends a 3-beat packet, source i data = 8'hi0..8'hi2 -> m_src order 0,1,2,3,0. Packets are contiguous, 1 bubble between packets, m_last on every 3rd beat.
- Backpressure: m_ready held low for 5 cycles mid-packet from source 2 -> m_data stays 8'h21 and stable, s_ready=4'b0000. After release, 8'h22 follows with no loss or duplication.
- Fixed priority (ARB_MODE=1): sources 1 and 3 valid continuously -> source 1 is granted every time and source 3 starves. Asserting only s_valid[3] -> source 3 is granted.
- Single-beat packets: source 0 sends 1-beat packets with data 8'hA5 repeatedly -> output period 2 cycles, m_last=1 and m_valid=1 on every beat.
- Source bubble: source 1 drops s_valid for 2 cycles mid-packet -> grant stays 1, m_valid=0 for 2 beats, then resumes. Other sources are not serviced until source 1's last beat.
- Reset mid-packet: assert rst for 1 cycle during beat 2 of 4 -> next cycle all outputs equal their reset values. Next grant starts from pointer 0.

Source files
------------

// File: rtl/axis_mux_pkg.sv
// Shared types and helpers for the AXI-Stream packet mux family
// (mux, and the future demux/crossbar that reuse the arbiter).
package axis_mux_pkg;

    // Packet-level FSM: IDLE arbitrates, XFER forwards one whole packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Arbitration modes.
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of an index able to address n sources (never below 1 bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational N-way arbiter. Round-robin scans upward from ptr_i with
// wrap-around; fixed priority always scans from index 0 (ptr_i ignored).
module axis_rr_arbiter
    import axis_mux_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int SRC_W    = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               any_req_o
);

    int               start;
    int               idx;
    logic [SRC_W-1:0] idx_s;
    logic             found;

    // First requester at or after the start index, wrapping past NUM_SRC-1.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        idx_s   = '0;
        start   = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr_i);
        for (int k = 0; k < NUM_SRC; k++) begin
            idx   = (start + k) % NUM_SRC;
            idx_s = SRC_W'(idx);
            if (!found && req_i[idx_s]) begin
                grant_o = idx_s;
                found   = 1'b1;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/axis_packet_mux.sv
// N-input to 1-output AXI-Stream packet multiplexer. Arbitration happens
// only between packets; the granted source's packet is forwarded beat by
// beat through a single registered output stage.
//
// Handshake: a beat moves on any interface exactly in the cycle where its
// valid and ready are both high at the rising edge. Valid never waits for
// ready; once the output presents a beat (m_valid=1) it holds m_* stable
// until m_ready accepts it. s_ready is the only combinational output and
// depends on m_ready/m_valid through can_load, never on s_valid.
module axis_packet_mux
    import axis_mux_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = ARB_RR,
    parameter int SRC_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        s_valid,
    input  logic [NUM_SRC-1:0]        s_last,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic                      m_valid,
    output logic                      m_last,
    output logic [DATA_W-1:0]         m_data,
    output logic [SRC_W-1:0]          m_src,
    input  logic                      m_ready,
    output logic                      busy
);

    state_t              state_q;
    logic [SRC_W-1:0]    grant_q;
    logic [SRC_W-1:0]    ptr_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;
    logic [SRC_W-1:0]    m_src_q;

    logic                can_load;
    logic [SRC_W-1:0]    arb_grant;
    logic                arb_any;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [SRC_W-1:0]    ptr_d;

    axis_rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE),
        .SRC_W    (SRC_W)
    ) u_arb (
        .req_i     (s_valid),
        .ptr_i     (ptr_q),
        .grant_o   (arb_grant),
        .any_req_o (arb_any)
    );

    // Output register may take a new value when empty or being drained.
    always_comb begin
        can_load = m_ready | ~m_valid_q;
    end

    // Select the granted source's beat and the pointer that follows it.
    always_comb begin
        sel_valid = s_valid[grant_q];
        sel_last  = s_last[grant_q];
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_data = s_data[i*DATA_W +: DATA_W];
            end
        end
        ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
    end

    // Only the granted source sees ready, and only while the output can load.
    always_comb begin
        s_ready = '0;
        if (state_q == XFER && can_load) begin
            s_ready[grant_q] = 1'b1;
        end
    end

    // Packet FSM together with the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_src_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Let the last beat of the previous packet drain.
                    if (can_load) begin
                        m_valid_q <= 1'b0;
                    end
                    if (arb_any) begin
                        grant_q <= arb_grant;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (can_load) begin
                        if (sel_valid) begin
                            m_valid_q <= 1'b1;
                            m_last_q  <= sel_last;
                            m_data_q  <= sel_data;
                            m_src_q   <= grant_q;
                            if (sel_last) begin
                                state_q <= IDLE;
                                ptr_q   <= ptr_d;
                            end
                        end else begin
                            // Source paused mid-packet: emit a bubble, keep the grant.
                            m_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Drive the registered outputs and the state flag.
    always_comb begin
        m_valid = m_valid_q;
        m_last  = m_last_q;
        m_data  = m_data_q;
        m_src   = m_src_q;
        busy    = (state_q == XFER);
    end

    // At most one source may be offered ready at any time.
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_ready));

endmodule

// File: tb/tb_axis_packet_mux.sv
// Directed bench for axis_packet_mux: a round-robin instance and a
// fixed-priority instance share the source/sink stimulus; each scenario is
// a per-cycle table of expected outputs plus an accepted-beat scoreboard.
module tb_axis_packet_mux;

    localparam int N = 4;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N*W-1:0] s_data;
    logic           m_ready;

    logic [N-1:0]   s_ready_a, s_ready_b;
    logic           m_valid_a, m_valid_b;
    logic           m_last_a, m_last_b;
    logic [W-1:0]   m_data_a, m_data_b;
    logic [1:0]     m_src_a, m_src_b;
    logic           busy_a, busy_b;

    axis_packet_mux #(.NUM_SRC(N), .DATA_W(W), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready_a), .m_valid(m_valid_a), .m_last(m_last_a), .m_data(m_data_a),
        .m_src(m_src_a), .m_ready(m_ready), .busy(busy_a)
    );

    axis_packet_mux #(.NUM_SRC(N), .DATA_W(W), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_data(m_data_b),
        .m_src(m_src_b), .m_ready(m_ready), .busy(busy_b)
    );

    // ---------------- source drivers ----------------
    int           pkts_left[N];
    int           beat[N];
    int           pkt_len;
    logic [W-1:0] base[N];
    logic [N-1:0] pause;
    bit           use_b;

    function automatic void drive_sources();
        for (int i = 0; i < N; i++) begin
            s_valid[i]       = (pkts_left[i] > 0) && !pause[i];
            s_last[i]        = (beat[i] == pkt_len - 1);
            s_data[i*W +: W] = base[i] + W'(beat[i]);
        end
    endfunction

    function automatic void source_edge(input logic [N-1:0] hs, input logic r);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                beat[i] = 0;
            end else if (hs[i]) begin
                if (beat[i] == pkt_len - 1) begin
                    beat[i] = 0;
                    pkts_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] pack(input logic [1:0] s, input logic l, input logic [7:0] d);
        return {5'b0, l, s, d};
    endfunction

    function automatic void push_pkt(input logic [1:0] s, input logic [7:0] first, input int len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(pack(s, k == len - 1, first + 8'(k)));
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         r;
        logic         mr;
        logic [N-1:0] pz;
        logic         mv;
        logic         ml;
        logic [W-1:0] md;
        logic [1:0]   ms;
        logic [N-1:0] sr;
        logic         bz;
        logic         ca;   // compare m_last/m_data/m_src even while m_valid=0
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic mr, input logic [N-1:0] pz,
                                input logic mv, input logic ml, input logic [W-1:0] md,
                                input logic [1:0] ms, input logic [N-1:0] sr,
                                input logic bz, input logic ca);
        vec_t v;
        v.r = r; v.mr = mr; v.pz = pz; v.mv = mv; v.ml = ml; v.md = md;
        v.ms = ms; v.sr = sr; v.bz = bz; v.ca = ca;
        tbl.push_back(v);
    endfunction

    // Bubble/idle row: nothing on the output, given s_ready and busy.
    function automatic void add_gap(input logic [N-1:0] sr, input logic bz);
        add(1'b0, 1'b1, '0, 1'b0, 1'b0, 8'h00, 2'd0, sr, bz, 1'b0);
    endfunction

    // Output beat row with the sink ready.
    function automatic void add_beat(input logic ml, input logic [W-1:0] md, input logic [1:0] ms,
                                     input logic [N-1:0] sr, input logic bz);
        add(1'b0, 1'b1, '0, 1'b1, ml, md, ms, sr, bz, 1'b0);
    endfunction

    task automatic start_scenario(input int len, input int p0, input int p1, input int p2,
                                  input int p3, input bit b);
        pkt_len   = len;
        pkts_left = '{p0, p1, p2, p3};
        beat      = '{default: 0};
        base      = '{8'h00, 8'h10, 8'h20, 8'h30};
        pause     = '0;
        use_b     = b;
        exp_q.delete();
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b1;
        drive_sources();
        @(posedge clk);
        source_edge('0, 1'b1);
    endtask

    task automatic run_table(input string tag);
        logic         mv, ml, bz;
        logic [W-1:0] md;
        logic [1:0]   ms;
        logic [N-1:0] sr, hs;
        logic [15:0]  e;
        logic         r;
        for (int c = 0; c < tbl.size(); c++) begin
            @(negedge clk);
            rst     = tbl[c].r;
            m_ready = tbl[c].mr;
            pause   = tbl[c].pz;
            drive_sources();
            #1;
            mv = use_b ? m_valid_b : m_valid_a;
            ml = use_b ? m_last_b  : m_last_a;
            md = use_b ? m_data_b  : m_data_a;
            ms = use_b ? m_src_b   : m_src_a;
            sr = use_b ? s_ready_b : s_ready_a;
            bz = use_b ? busy_b    : busy_a;
            chk($sformatf("%s c%0d m_valid", tag, c), 32'(mv), 32'(tbl[c].mv));
            chk($sformatf("%s c%0d s_ready", tag, c), 32'(sr), 32'(tbl[c].sr));
            chk($sformatf("%s c%0d busy", tag, c), 32'(bz), 32'(tbl[c].bz));
            if (tbl[c].mv || tbl[c].ca) begin
                chk($sformatf("%s c%0d m_last", tag, c), 32'(ml), 32'(tbl[c].ml));
                chk($sformatf("%s c%0d m_data", tag, c), 32'(md), 32'(tbl[c].md));
                chk($sformatf("%s c%0d m_src", tag, c), 32'(ms), 32'(tbl[c].ms));
            end
            if (mv && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s c%0d sb_extra: got beat %0h expected none", tag, c,
                             pack(ms, ml, md));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s c%0d sb_beat", tag, c), 32'(pack(ms, ml, md)), 32'(e));
                end
            end
            hs = s_valid & sr;
            r  = tbl[c].r;
            @(posedge clk);
            source_edge(hs, r);
        end
        chk($sformatf("%s sb_left", tag), 32'(exp_q.size()), 32'd0);
        tbl.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        pause   = '0;

        // Round-robin fairness: all four sources, 3-beat packets, source 0 twice.
        start_scenario(3, 2, 1, 1, 1, 1'b0);
        push_pkt(0, 8'h00, 3); push_pkt(1, 8'h10, 3); push_pkt(2, 8'h20, 3);
        push_pkt(3, 8'h30, 3); push_pkt(0, 8'h00, 3);
        add(1'b0, 1'b1, '0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0, 1'b1);
        add_gap(4'b0001, 1'b1);
        add_beat(1'b0, 8'h00, 2'd0, 4'b0001, 1'b1);
        add_beat(1'b0, 8'h01, 2'd0, 4'b0001, 1'b1);
        add_beat(1'b1, 8'h02, 2'd0, 4'b0000, 1'b0);
        add_gap(4'b0010, 1'b1);
        add_beat(1'b0, 8'h10, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b0, 8'h11, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b1, 8'h12, 2'd1, 4'b0000, 1'b0);
        add_gap(4'b0100, 1'b1);
        add_beat(1'b0, 8'h20, 2'd2, 4'b0100, 1'b1);
        add_beat(1'b0, 8'h21, 2'd2, 4'b0100, 1'b1);
        add_beat(1'b1, 8'h22, 2'd2, 4'b0000, 1'b0);
        add_gap(4'b1000, 1'b1);
        add_beat(1'b0, 8'h30, 2'd3, 4'b1000, 1'b1);
        add_beat(1'b0, 8'h31, 2'd3, 4'b1000, 1'b1);
        add_beat(1'b1, 8'h32, 2'd3, 4'b0000, 1'b0);
        add_gap(4'b0001, 1'b1);
        add_beat(1'b0, 8'h00, 2'd0, 4'b0001, 1'b1);
        add_beat(1'b0, 8'h01, 2'd0, 4'b0001, 1'b1);
        add_beat(1'b1, 8'h02, 2'd0, 4'b0000, 1'b0);
        add_gap(4'b0000, 1'b0);
        run_table("rr");

        // Sink backpressure: m_ready low for 5 cycles while 8'h21 is presented.
        start_scenario(3, 0, 0, 1, 0, 1'b0);
        push_pkt(2, 8'h20, 3);
        add_gap(4'b0000, 1'b0);
        add_gap(4'b0100, 1'b1);
        add_beat(1'b0, 8'h20, 2'd2, 4'b0100, 1'b1);
        for (int k = 0; k < 5; k++) begin
            add(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h21, 2'd2, 4'b0000, 1'b1, 1'b0);
        end
        add_beat(1'b0, 8'h21, 2'd2, 4'b0100, 1'b1);
        add_beat(1'b1, 8'h22, 2'd2, 4'b0000, 1'b0);
        add_gap(4'b0000, 1'b0);
        run_table("bp");

        // Single-beat packets 8'hA5 from source 0: one beat every 2 cycles.
        start_scenario(1, 3, 0, 0, 0, 1'b0);
        base[0] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(2'd0, 1'b1, 8'hA5));
        end
        add_gap(4'b0000, 1'b0);
        add_gap(4'b0001, 1'b1);
        add_beat(1'b1, 8'hA5, 2'd0, 4'b0000, 1'b0);
        add_gap(4'b0001, 1'b1);
        add_beat(1'b1, 8'hA5, 2'd0, 4'b0000, 1'b0);
        add_gap(4'b0001, 1'b1);
        add_beat(1'b1, 8'hA5, 2'd0, 4'b0000, 1'b0);
        add_gap(4'b0000, 1'b0);
        run_table("single");

        // Source 1 pauses for 2 cycles mid-packet while source 2 waits.
        start_scenario(3, 0, 1, 1, 0, 1'b0);
        push_pkt(1, 8'h10, 3); push_pkt(2, 8'h20, 3);
        add_gap(4'b0000, 1'b0);
        add_gap(4'b0010, 1'b1);
        add(1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h10, 2'd1, 4'b0010, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0010, 1'b1, 1'b0);
        add_gap(4'b0010, 1'b1);
        add_beat(1'b0, 8'h11, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b1, 8'h12, 2'd1, 4'b0000, 1'b0);
        add_gap(4'b0100, 1'b1);
        add_beat(1'b0, 8'h20, 2'd2, 4'b0100, 1'b1);
        add_beat(1'b0, 8'h21, 2'd2, 4'b0100, 1'b1);
        add_beat(1'b1, 8'h22, 2'd2, 4'b0000, 1'b0);
        add_gap(4'b0000, 1'b0);
        run_table("bubble");

        // Reset during beat 2 of a 4-beat packet from source 3; pointer restarts at 0.
        start_scenario(4, 0, 2, 0, 1, 1'b0);
        push_pkt(1, 8'h10, 4);
        exp_q.push_back(pack(2'd3, 1'b0, 8'h30));
        exp_q.push_back(pack(2'd3, 1'b0, 8'h31));
        exp_q.push_back(pack(2'd1, 1'b0, 8'h10));
        add_gap(4'b0000, 1'b0);
        add_gap(4'b0010, 1'b1);
        add_beat(1'b0, 8'h10, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b0, 8'h11, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b0, 8'h12, 2'd1, 4'b0010, 1'b1);
        add_beat(1'b1, 8'h13, 2'd1, 4'b0000, 1'b0);
        add_gap(4'b1000, 1'b1);
        add_beat(1'b0, 8'h30, 2'd3, 4'b1000, 1'b1);
        add(1'b1, 1'b1, '0, 1'b1, 1'b0, 8'h31, 2'd3, 4'b1000, 1'b1, 1'b0);
        add(1'b0, 1'b1, '0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0, 1'b1);
        add_gap(4'b0010, 1'b1);
        add_beat(1'b0, 8'h10, 2'd1, 4'b0010, 1'b1);
        run_table("rst");

        // Fixed priority: sources 1 and 3 request; 1 wins until it runs dry.
        start_scenario(2, 0, 3, 0, 1, 1'b1);
        push_pkt(1, 8'h10, 2); push_pkt(1, 8'h10, 2); push_pkt(1, 8'h10, 2);
        push_pkt(3, 8'h30, 2);
        add(1'b0, 1'b1, '0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            add_gap(4'b0010, 1'b1);
            add_beat(1'b0, 8'h10, 2'd1, 4'b0010, 1'b1);
            add_beat(1'b1, 8'h11, 2'd1, 4'b0000, 1'b0);
        end
        add_gap(4'b1000, 1'b1);
        add_beat(1'b0, 8'h30, 2'd3, 4'b1000, 1'b1);
        add_beat(1'b1, 8'h31, 2'd3, 4'b0000, 1'b0);
        add_gap(4'b0000, 1'b0);
        run_table("fixed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
